dual_priority_encoder: RTL and testbench

- Registered dual priority encoder over a 12-bit request vector.
- Each cycle it reports the highest-priority active request (p1) and the second-highest active request (p2).
- Priority is by bit index: r[11] is highest, r[0] is lowest.
- Sits between request sources and arbitration/display logic; one clock domain.

---
 rtl/dual_prio_pkg.sv | 18 +
 rtl/prio_enc.sv | 30 +++
 rtl/dual_priority_encoder.sv | 71 +++++++
 tb/tb_dual_priority_encoder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dual_prio_pkg.sv
// ----------------------------------------------------------------------------
// dual_prio_pkg
// Shared constants and types for the dual priority encoder.
//   REQ_W     : number of request lines
//   CODE_W    : width of an encoded request code (2**CODE_W > REQ_W)
//   code_t    : encoded request type; request i is reported as code i+1
//   CODE_NONE : code meaning "no request"
// ----------------------------------------------------------------------------
package dual_prio_pkg;

   localparam int REQ_W  = 12;
   localparam int CODE_W = 4;

   typedef logic [CODE_W-1:0] code_t;

   localparam code_t CODE_NONE = '0;

endpackage : dual_prio_pkg

// File: rtl/prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc
// Combinational highest-index priority encoder.
// Ports:
//   req  : request vector, bit i set = request i active
//   code : index+1 of the highest set bit, CODE_NONE when req is empty
//   any  : 1 when at least one request bit is set
// ----------------------------------------------------------------------------
module prio_enc
   import dual_prio_pkg::*;
(
   input  logic [REQ_W-1:0] req,
   output code_t            code,
   output logic             any
);

   // Ascending scan: a later (higher) set bit overwrites earlier ones, so the
   // highest index wins.
   always_comb begin
      code = CODE_NONE;
      any  = 1'b0;
      for (int i = 0; i < REQ_W; i++) begin
         if (req[i]) begin
            code = code_t'(i + 1);
            any  = 1'b1;
         end
      end
   end

endmodule : prio_enc

// File: rtl/dual_priority_encoder.sv
// ----------------------------------------------------------------------------
// dual_priority_encoder
// Registered dual priority encoder: reports the highest and second-highest
// active request of a REQ_W-bit vector, one clock of latency.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset, clears all outputs
//   r        : request vector, r[REQ_W-1] highest priority
//   p1       : code of highest active request (index+1), 0 if none
//   p2       : code of second-highest active request, 0 if fewer than two
//   p1_valid : at least one request was active
//   p2_valid : at least two requests were active
// ----------------------------------------------------------------------------
module dual_priority_encoder
   import dual_prio_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [REQ_W-1:0] r,
   output code_t            p1,
   output code_t            p2,
   output logic             p1_valid,
   output logic             p2_valid
);

   code_t            code_hi;
   code_t            code_lo;
   logic             any_hi;
   logic             any_lo;
   logic [REQ_W-1:0] win_onehot;
   logic [REQ_W-1:0] masked;

   prio_enc u_enc_hi (
      .req  (r),
      .code (code_hi),
      .any  (any_hi)
   );

   // One-hot decode of the winning code; CODE_NONE matches no bit, so an
   // empty request leaves the mask all-zero.
   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < REQ_W; i++) begin
         win_onehot[i] = (code_hi == code_t'(i + 1));
      end
   end

   assign masked = r & ~win_onehot;

   prio_enc u_enc_lo (
      .req  (masked),
      .code (code_lo),
      .any  (any_lo)
   );

   // Output register stage: everything visible to the outside is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1       <= CODE_NONE;
         p2       <= CODE_NONE;
         p1_valid <= 1'b0;
         p2_valid <= 1'b0;
      end else begin
         p1       <= code_hi;
         p2       <= code_lo;
         p1_valid <= any_hi;
         p2_valid <= any_lo;
      end
   end

endmodule : dual_priority_encoder

// File: tb/tb_dual_priority_encoder.sv
module tb_dual_priority_encoder;
   import dual_prio_pkg::*;

   logic             clk;
   logic             reset;
   logic [REQ_W-1:0] r;
   code_t            p1;
   code_t            p2;
   logic             p1_valid;
   logic             p2_valid;

   int n_checks;
   int n_pass;

   dual_priority_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .r        (r),
      .p1       (p1),
      .p2       (p2),
      .p1_valid (p1_valid),
      .p2_valid (p2_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: list active indices from highest to lowest; first two entries
   // give the codes, list length gives the valids.
   task automatic model(input logic [REQ_W-1:0] v,
                        output int e1, output int e2,
                        output int ev1, output int ev2);
      int q[$];
      for (int i = REQ_W - 1; i >= 0; i--)
         if (v[i]) q.push_back(i);
      e1  = (q.size() >= 1) ? q[0] + 1 : 0;
      e2  = (q.size() >= 2) ? q[1] + 1 : 0;
      ev1 = (q.size() >= 1) ? 1 : 0;
      ev2 = ($countones(v) >= 2) ? 1 : 0;
   endtask

   task automatic check_outputs(input string tag, input logic [REQ_W-1:0] v);
      int e1, e2, ev1, ev2;
      model(v, e1, e2, ev1, ev2);
      check({tag, ".p1"}, int'(p1), e1);
      check({tag, ".p2"}, int'(p2), e2);
      check({tag, ".p1_valid"}, int'(p1_valid), ev1);
      check({tag, ".p2_valid"}, int'(p2_valid), ev2);
   endtask

   task automatic apply(input string tag, input logic [REQ_W-1:0] v);
      r = v;
      @(posedge clk);
      #1;
      check_outputs(tag, v);
   endtask

   initial begin
      logic [REQ_W-1:0] v;
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      r        = 12'hFFF;

      // Reset held two cycles with all requests active.
      repeat (2) @(posedge clk);
      #1;
      check("rst.p1", int'(p1), 0);
      check("rst.p2", int'(p2), 0);
      check("rst.p1_valid", int'(p1_valid), 0);
      check("rst.p2_valid", int'(p2_valid), 0);

      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.p1", int'(p1), 12);
      check("post_rst.p2", int'(p2), 11);
      check("post_rst.p1_valid", int'(p1_valid), 1);
      check("post_rst.p2_valid", int'(p2_valid), 1);

      // Outputs must not follow r until the next edge.
      r = 12'b0000_1000_0000;
      #2;
      check("no_comb.p1", int'(p1), 12);
      check("no_comb.p2", int'(p2), 11);

      apply("single11", 12'b1000_0000_0000);
      apply("single7",  12'b0000_1000_0000);
      apply("two76",    12'b0000_1100_0000);
      apply("two75",    12'b0000_1010_0000);
      apply("two73",    12'b0000_1000_1000);
      apply("three",    12'b0000_1010_1000);
      apply("ext11_0",  12'b1000_0000_0001);
      apply("only0",    12'b0000_0000_0001);
      apply("all",      12'hFFF);
      apply("zero",     12'h000);
      apply("hold0",    12'h000);

      // Reset asserted mid-stream overrides a busy request vector.
      reset = 1'b1;
      r     = 12'hA5A;
      @(posedge clk);
      #1;
      check("rst2.p1", int'(p1), 0);
      check("rst2.p2_valid", int'(p2_valid), 0);
      reset = 1'b0;
      apply("after_rst2", 12'hA5A);

      // Random vectors, a new one every cycle; includes sparse ones so that
      // single-bit and empty cases recur.
      for (int k = 0; k < 1000; k++) begin
         v = REQ_W'($urandom);
         if (k % 4 == 1) v = v & REQ_W'($urandom);
         if (k % 4 == 2) v = v & REQ_W'($urandom) & REQ_W'($urandom);
         apply("rand", v);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dual_priority_encoder
